membus_ram_responder: RTL

- Word-addressed RAM that acts as the responder on the MemBus request/response interface.
- It sits behind the data and instruction caches, directly or after an arbiter, and serves as the backing store for simulation and FPGA builds.
- Writes are posted: they complete when accepted and produce no response.
- Reads return exactly one response pulse a fixed LATENCY cycles after acceptance.

---
 rtl/membus_ram_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/membus_ram_responder.sv
// Word-addressed RAM responder on the MemBus request/response interface: posted writes, fixed-latency reads.
// Optional `MEMBUS_RAND_STALL_EN adds LFSR-driven back-pressure on busreq_ready while idle.
module membus_ram_responder #(
   parameter int          MEM_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busreq_valid,
   output logic        busreq_ready,
   input  logic [31:0] busreq_addr,
   input  logic        busreq_wen,
   input  logic [31:0] busreq_wdata,
   output logic        busresp_valid,
   output logic [31:0] busresp_rdata,
   output logic        busresp_error
);

   localparam logic [32:0] MEM_BYTES = 33'(4) << MEM_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   generate
      if (LATENCY < 1 || LATENCY > 15 ||
          (64'(BASE_ADDR) % (64'd4 << MEM_WIDTH)) != 64'd0) begin : g_bad_param
         initial begin
            $display("membus_ram_responder: illegal LATENCY=%0d or misaligned BASE_ADDR=%h",
                     LATENCY, BASE_ADDR);
            $finish;
         end
      end
   endgenerate

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [31:0]    pend_rdata_q, pend_rdata_d;
   logic           pend_err_q, pend_err_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;

   logic [31:0]    mem [2**MEM_WIDTH];
   logic [32:0]    offset;
   logic           legal;
   logic [MEM_WIDTH-1:0] idx;
   logic [31:0]    rd_word;
   logic           accept;

   // A 33-bit offset keeps the top of the window from wrapping; addresses below the base wrap huge.
   always_comb begin
      offset  = {1'b0, busreq_addr} - {1'b0, BASE_ADDR};
      legal   = (offset < MEM_BYTES) && (offset[1:0] == 2'b00);
      idx     = offset[MEM_WIDTH+1:2];
      rd_word = legal ? mem[idx] : 32'h0;
      accept  = busreq_valid && busreq_ready;
   end

   // NOTE: the RAM array has no reset branch; clearing it would forbid block-RAM inference.
   always_ff @(posedge clk) begin
      if (!reset && accept && busreq_wen && legal) begin
         mem[idx] <= busreq_wdata;
      end
   end

`ifdef MEMBUS_RAND_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= lfsr_d;
   end
`endif

   // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         pend_rdata_q <= 32'h0;
         pend_err_q   <= 1'b0;
         rdata_q      <= 32'h0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_rdata_q <= pend_rdata_d;
         pend_err_q   <= pend_err_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // NOTE: every _d signal takes its hold value first, so no path through this block can infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_rdata_d = pend_rdata_q;
      pend_err_d   = pend_err_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && !busreq_wen) begin
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  rdata_d = rd_word;
                  err_d   = !legal;
               end else begin
                  state_d      = S_WAIT;
                  cnt_d        = 4'(LATENCY - 2);
                  pend_rdata_d = rd_word;
                  pend_err_d   = !legal;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               rdata_d = pend_rdata_q;
               err_d   = pend_err_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busreq_ready  = !reset && (state_q == S_IDLE);
`ifdef MEMBUS_RAND_STALL_EN
      busreq_ready  = busreq_ready && (lfsr_q[1:0] != 2'b00);
`endif
      busresp_valid = (state_q == S_RESP);
      busresp_rdata = rdata_q;
      busresp_error = err_q;
   end

endmodule
